// File: rtl/decode_stage.sv
// decode_stage: ID stage with register file, decoder, beq resolution and hazard stalls
module decode_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    ifid_pc_next,
  input  logic [WIDTH-1:0]    ifid_instruction,
  input  logic                wb_reg_write,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic [WIDTH-1:0]    wb_data,
  input  logic                exmem_mem_read,
  input  logic [REG_BITS-1:0] exmem_rd,
  output logic                pc_src,
  output logic [WIDTH-1:0]    branch_target,
  output logic                pc_enable,
  output logic                ifid_enable,
  output logic                ifid_flush,
  output logic [WIDTH-1:0]    idex_pc_next,
  output logic [WIDTH-1:0]    idex_rs_data,
  output logic [WIDTH-1:0]    idex_rt_data,
  output logic [WIDTH-1:0]    idex_imm,
  output logic [REG_BITS-1:0] idex_rs,
  output logic [REG_BITS-1:0] idex_rt,
  output logic [REG_BITS-1:0] idex_rd,
  output logic [3:0]          idex_alu_op,
  output logic                idex_alu_src,
  output logic                idex_mem_read,
  output logic                idex_mem_write,
  output logic                idex_reg_write,
  output logic                idex_mem_to_reg,
  output logic                idex_illegal
);
  logic [WIDTH-1:0]    regs [2**REG_BITS];
  logic [5:0]          op, funct;
  logic [REG_BITS-1:0] rs, rt, rd, dest;
  logic [WIDTH-1:0]    imm, rs_data, rt_data;
  logic                is_r, r_ok, is_lw, is_sw, is_addi, is_beq, illegal;
  logic                reg_write, alu_src, stall, taken;
  logic [3:0]          alu_op, alu_op_r;

  // Field extraction, bypassed register reads and control decode
  always_comb begin
    op       = ifid_instruction[31:26];
    rs       = ifid_instruction[25:21];
    rt       = ifid_instruction[20:16];
    rd       = ifid_instruction[15:11];
    funct    = ifid_instruction[5:0];
    imm      = {{(WIDTH-16){ifid_instruction[15]}}, ifid_instruction[15:0]};
    rs_data  = (rs == '0) ? '0 : (wb_reg_write && wb_rd == rs) ? wb_data : regs[rs];
    rt_data  = (rt == '0) ? '0 : (wb_reg_write && wb_rd == rt) ? wb_data : regs[rt];
    is_r     = op == 6'h00;
    is_lw    = op == 6'h23;
    is_sw    = op == 6'h2B;
    is_addi  = op == 6'h08;
    is_beq   = op == 6'h04;
    r_ok     = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                        funct == 6'h25 || funct == 6'h2A);
    alu_op_r = (funct == 6'h22) ? 4'b0110 : (funct == 6'h24) ? 4'b0000 :
               (funct == 6'h25) ? 4'b0001 : (funct == 6'h2A) ? 4'b0111 : 4'b0010;
    illegal  = !((is_r && (r_ok || funct == 6'h00)) || is_lw || is_sw || is_addi || is_beq);
    reg_write = r_ok || is_lw || is_addi;
    alu_src  = is_lw || is_sw || is_addi;
    alu_op   = r_ok ? alu_op_r : alu_src ? 4'b0010 : 4'b0000;
    dest     = !reg_write ? '0 : r_ok ? rd : rt;
  end

  // Hazard detection and branch resolution feeding fetch
  always_comb begin
    stall = (idex_mem_read && idex_rd != '0 && (idex_rd == rs || idex_rd == rt)) ||
            (is_beq && idex_reg_write && idex_rd != '0 && (idex_rd == rs || idex_rd == rt)) ||
            (is_beq && exmem_mem_read && exmem_rd != '0 && (exmem_rd == rs || exmem_rd == rt));
    taken         = is_beq && !stall && rs_data == rt_data;
    pc_src        = !taken;
    ifid_flush    = taken;
    pc_enable     = !stall;
    ifid_enable   = !stall;
    branch_target = ifid_pc_next + (imm << 2);
  end

  // Register file; r0 is never written so it always reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 2**REG_BITS; i++) regs[i] <= '0;
    else if (wb_reg_write && wb_rd != '0) regs[wb_rd] <= wb_data;
  end

  // ID/EX pipeline register; a stall turns the slot into a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_pc_next    <= '0;
      idex_rs_data    <= '0;
      idex_rt_data    <= '0;
      idex_imm        <= '0;
      idex_rs         <= '0;
      idex_rt         <= '0;
      idex_rd         <= '0;
      idex_alu_op     <= '0;
      idex_alu_src    <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_illegal    <= 1'b0;
    end else begin
      idex_pc_next    <= ifid_pc_next;
      idex_rs_data    <= rs_data;
      idex_rt_data    <= rt_data;
      idex_imm        <= imm;
      idex_rs         <= rs;
      idex_rt         <= rt;
      idex_rd         <= stall ? '0 : dest;
      idex_alu_op     <= stall ? 4'b0000 : alu_op;
      idex_alu_src    <= !stall && alu_src;
      idex_mem_read   <= !stall && is_lw;
      idex_mem_write  <= !stall && is_sw;
      idex_reg_write  <= !stall && reg_write;
      idex_mem_to_reg <= !stall && is_lw;
      idex_illegal    <= !stall && illegal;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] ifid_pc_next = '0, ifid_instruction = '0, wb_data = '0;
  logic        wb_reg_write = 1'b0, exmem_mem_read = 1'b0;
  logic [4:0]  wb_rd = '0, exmem_rd = '0;
  logic        pc_src, pc_enable, ifid_enable, ifid_flush;
  logic [31:0] branch_target, idex_pc_next, idex_rs_data, idex_rt_data, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [3:0]  idex_alu_op;
  logic        idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write, idex_mem_to_reg, idex_illegal;
  int checks = 0, failures = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .ifid_pc_next(ifid_pc_next), .ifid_instruction(ifid_instruction),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .exmem_mem_read(exmem_mem_read), .exmem_rd(exmem_rd),
    .pc_src(pc_src), .branch_target(branch_target), .pc_enable(pc_enable),
    .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_pc_next(idex_pc_next), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
    .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_alu_op(idex_alu_op), .idex_alu_src(idex_alu_src), .idex_mem_read(idex_mem_read),
    .idex_mem_write(idex_mem_write), .idex_reg_write(idex_reg_write),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_illegal(idex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wb_reg_write = 1'b1; wb_rd = r; wb_data = d;
    step;
    wb_reg_write = 1'b0;
  endtask

  function automatic logic [31:0] rt_i(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  initial begin
    #1;
    chk("rst_reg_write", {31'd0, idex_reg_write}, 32'd0);
    chk("rst_rs_data", idex_rs_data, 32'd0);
    chk("rst_pc_src", {31'd0, pc_src}, 32'd1);
    step;
    reset = 1'b0;
    step;
    // read-during-write bypass
    ifid_instruction = rt_i(5'd3, 5'd3, 5'd4, 6'h20);
    wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    step;
    wb_reg_write = 1'b0;
    chk("byp_rs_data", idex_rs_data, 32'h1234);
    chk("byp_rt_data", idex_rt_data, 32'h1234);
    chk("add_rd", {27'd0, idex_rd}, 32'd4);
    chk("add_alu_op", {28'd0, idex_alu_op}, 32'h2);
    chk("add_reg_write", {31'd0, idex_reg_write}, 32'd1);
    ifid_instruction = rt_i(5'd3, 5'd0, 5'd4, 6'h22);
    step;
    chk("r3_stored", idex_rs_data, 32'h1234);
    chk("sub_alu_op", {28'd0, idex_alu_op}, 32'h6);
    chk("r0_read", idex_rt_data, 32'd0);
    // load-use stall
    ifid_instruction = '0;
    wr(5'd1, 32'h100);
    ifid_instruction = it_i(6'h23, 5'd1, 5'd2, 16'h0000);
    step;
    chk("lw_mem_read", {31'd0, idex_mem_read}, 32'd1);
    chk("lw_mem_to_reg", {31'd0, idex_mem_to_reg}, 32'd1);
    chk("lw_alu_src", {31'd0, idex_alu_src}, 32'd1);
    chk("lw_rd", {27'd0, idex_rd}, 32'd2);
    ifid_instruction = rt_i(5'd2, 5'd2, 5'd5, 6'h20);
    #1;
    chk("lu_pc_enable", {31'd0, pc_enable}, 32'd0);
    chk("lu_ifid_enable", {31'd0, ifid_enable}, 32'd0);
    chk("lu_pc_src", {31'd0, pc_src}, 32'd1);
    step;
    chk("lu_bubble_rw", {31'd0, idex_reg_write}, 32'd0);
    chk("lu_bubble_mr", {31'd0, idex_mem_read}, 32'd0);
    chk("lu_release", {31'd0, pc_enable}, 32'd1);
    step;
    chk("lu_issue_rw", {31'd0, idex_reg_write}, 32'd1);
    chk("lu_issue_rd", {27'd0, idex_rd}, 32'd5);
    // taken branch backward
    ifid_instruction = it_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    ifid_pc_next = 32'h10;
    #1;
    chk("beq_pc_src", {31'd0, pc_src}, 32'd0);
    chk("beq_target", branch_target, 32'h0C);
    chk("beq_flush", {31'd0, ifid_flush}, 32'd1);
    chk("beq_pc_enable", {31'd0, pc_enable}, 32'd1);
    step;
    chk("beq_bubble", {31'd0, idex_reg_write}, 32'd0);
    chk("beq_legal", {31'd0, idex_illegal}, 32'd0);
    // not taken, then branch hazard on addi result
    ifid_instruction = '0;
    wr(5'd6, 32'd1);
    wr(5'd7, 32'd2);
    ifid_instruction = it_i(6'h04, 5'd6, 5'd7, 16'd3);
    ifid_pc_next = 32'h20;
    #1;
    chk("nt_pc_src", {31'd0, pc_src}, 32'd1);
    chk("nt_flush", {31'd0, ifid_flush}, 32'd0);
    chk("fwd_target", branch_target, 32'h2C);
    ifid_instruction = it_i(6'h08, 5'd0, 5'd6, 16'd2);
    step;
    chk("addi_imm", idex_imm, 32'd2);
    chk("addi_rd", {27'd0, idex_rd}, 32'd6);
    ifid_instruction = it_i(6'h04, 5'd6, 5'd7, 16'd3);
    #1;
    chk("bh_pc_enable", {31'd0, pc_enable}, 32'd0);
    chk("bh_pc_src", {31'd0, pc_src}, 32'd1);
    chk("bh_flush", {31'd0, ifid_flush}, 32'd0);
    step;
    wb_reg_write = 1'b1; wb_rd = 5'd6; wb_data = 32'd2;
    #1;
    chk("bh_resolve_en", {31'd0, pc_enable}, 32'd1);
    chk("bh_resolve_src", {31'd0, pc_src}, 32'd0);
    exmem_mem_read = 1'b1; exmem_rd = 5'd7;
    #1;
    chk("bc_exmem_stall", {31'd0, pc_enable}, 32'd0);
    chk("bc_exmem_src", {31'd0, pc_src}, 32'd1);
    exmem_mem_read = 1'b0;
    step;
    wb_reg_write = 1'b0;
    // wrap-around target
    ifid_instruction = it_i(6'h04, 5'd0, 5'd0, 16'd1);
    ifid_pc_next = 32'hFFFF_FFFC;
    #1;
    chk("wrap_target", branch_target, 32'h0);
    // illegal opcode, illegal funct, nop, sw
    ifid_instruction = 32'hFC00_0000;
    step;
    chk("ill_op", {31'd0, idex_illegal}, 32'd1);
    chk("ill_ctrl", {26'd0, idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write, idex_mem_to_reg, idex_alu_op == 4'd0}, 32'd1);
    ifid_instruction = rt_i(5'd1, 5'd1, 5'd1, 6'h3F);
    step;
    chk("ill_funct", {31'd0, idex_illegal}, 32'd1);
    ifid_instruction = '0;
    step;
    chk("nop_legal", {31'd0, idex_illegal}, 32'd0);
    chk("nop_rw", {31'd0, idex_reg_write}, 32'd0);
    ifid_instruction = it_i(6'h2B, 5'd1, 5'd2, 16'hFFF8);
    step;
    chk("sw_mem_write", {31'd0, idex_mem_write}, 32'd1);
    chk("sw_imm", idex_imm, 32'hFFFF_FFF8);
    chk("sw_rw", {31'd0, idex_reg_write}, 32'd0);
    ifid_instruction = '0;
    wr(5'd0, 32'hFFFF);
    ifid_instruction = rt_i(5'd0, 5'd0, 5'd8, 6'h25);
    step;
    chk("r0_after_wr", idex_rs_data, 32'd0);
    chk("or_alu_op", {28'd0, idex_alu_op}, 32'h1);
    // asynchronous reset mid-run
    ifid_instruction = '0;
    wr(5'd5, 32'h55);
    ifid_instruction = rt_i(5'd5, 5'd5, 5'd9, 6'h2A);
    step;
    chk("slt_alu_op", {28'd0, idex_alu_op}, 32'h7);
    chk("pre_rst_data", idex_rs_data, 32'h55);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rw", {31'd0, idex_reg_write}, 32'd0);
    chk("arst_data", idex_rs_data, 32'd0);
    chk("arst_op", {28'd0, idex_alu_op}, 32'd0);
    step;
    reset = 1'b0;
    step;
    chk("r5_cleared", idex_rs_data, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
